ofifo_banked: RTL and testbench
===============================

# ofifo_banked

Parametrised output FIFO bank for the systolic-array datapath: `COL` independent lanes of `BW`-bit entries, `DEPTH` entries deep. Each column's psum stream is written on its own write strobe; rows are drained in lockstep only when every lane holds data. This is the next-generation column output buffer between the array's bottom edge and the SRAM write-back path. It adds configurable depth, row occupancy, almost-full backpressure, registered read data with a valid strobe, and optional error flags.

## Interface
- `COL`, 8, number of lanes (array columns)
- `BW`, 4, bits per lane entry
- `DEPTH`, 64, entries per lane; power of two, ≥ 2
- `AF_LVL`, `DEPTH-4`, almost-full threshold; 1 ≤ `AF_LVL` ≤ `DEPTH`
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `in`  in  `BW*COL`  write data; lane i = `in[BW*i +: BW]`
- `wr`  in  `COL`  per-lane write strobe
- `rd`  in  1  row read request
- `out`  out  `BW*COL`  registered row data; lane i = `out[BW*i +: BW]`
- `o_out_vld`  out  1  `out` holds a freshly popped row this cycle
- `o_valid`  out  1  every lane non-empty, so a row is available
- `o_empty`  out  1  every lane empty
- `o_ready`  out  1  no lane full
- `o_full`  out  1  every lane full
- `o_afull`  out  1  some lane count ≥ `AF_LVL`
- `o_level`  out  `$clog2(DEPTH)+1`  minimum lane count, i.e. complete rows held
- `o_ovf`, `o_udf`  out  1  sticky error flags; present only with `OFIFO_ERR_EN`

## Operation
- Each lane keeps write pointer, read pointer and count (0..`DEPTH`). Pointers are `$clog2(DEPTH)` bits and wrap naturally.
- Row accept: `rd_acc = rd & o_valid`. On `rd_acc`, every lane pops its head entry.
- Lane write accept: `wr[i] & (~full_i | rd_acc)`.
  - A full lane still accepts when a row pop happens in the same cycle; its count is unchanged.
- Lane write with `wr[i] & full_i & ~rd_acc`: the write is dropped, and pointer and count are unchanged.
- Simultaneous accepted write and pop on one lane: count is unchanged and both pointers advance.
- `rd` with `~o_valid`: ignored. `out` holds its value and `o_out_vld` is 0.
- Status outputs are combinational from the current counts:
  - `o_valid`, `o_empty`, `o_ready`, `o_full` and `o_afull` follow the per-lane counts as listed in Interface.
  - `o_level` = min over lanes of count.
- Lanes may fill unevenly. A row is only as complete as its least-filled lane.

## Timing
- Reset values (applied on the `clk` edge while `reset`=1):
  - all pointers and counts 0, `out`=0, `o_out_vld`=0
  - `o_ovf`=`o_udf`=0
  - hence `o_empty`=1, `o_ready`=1, `o_valid`=0, `o_full`=0, `o_afull`=0, `o_level`=0
- Reset has priority over `rd` and `wr` in the same cycle. Reset mid-stream discards all contents.
- Write latency: data written at edge k is poppable from cycle k+1 (`o_valid` rises in cycle k+1 if all lanes are then non-empty).
- Read latency 1: with `rd_acc` sampled at edge k, `out` carries the popped row and `o_out_vld`=1 during cycle k+1.
- `o_out_vld` is a one-cycle pulse per popped row. Back-to-back `rd` gives one row per cycle.
- No bypass: a write to an empty lane cannot be popped in the same cycle.

## Configuration
- `OFIFO_ERR_EN` defined:
  - `o_ovf` sets on any dropped lane write.
  - `o_udf` sets on `rd & ~o_valid`.
  - Both are sticky until `reset`.
- `OFIFO_ERR_EN` undefined: the ports and their logic are absent. Drops and ignored reads are silent.

## Structure
- Package `ofifo_pkg`: pointer width `$clog2(DEPTH)`, count width `$clog2(DEPTH)+1`, default parameter constants.
- Sub-module `ofifo_lane`: one `BW`-wide, `DEPTH`-deep lane with ports `push`, `pop`, `din`, `dout` (head, combinational), `count`, `full`, `empty`.
- `ofifo_banked` instantiates `COL` lanes via generate. It computes `rd_acc`, the status reduction including the `o_level` minimum, the output register and the error flags.

## Test plan
- Reset, then write rows 0x1..0x4 on all lanes (`wr`=0xFF, one row per cycle), then `rd` for 4 cycles:
  - `out` = the rows in order, one cycle after each `rd`
  - `o_out_vld` high for 4 cycles
  - ends with `o_empty`=1, `o_level`=0
- Write lane 0 only, 3 times, then assert `rd`:
  - `o_valid`=0, `o_out_vld` stays 0, `o_level`=0
  - `o_udf`=1 with `OFIFO_ERR_EN`
- Fill all lanes to `DEPTH`=64:
  - `o_afull` rises at count 60, `o_full`=1 and `o_ready`=0 at 64
  - one extra write is dropped, `o_level` stays 64, `o_ovf`=1
- With all lanes full, apply `wr`=0xFF and `rd` together:
  - the oldest row pops, the new row is accepted, `o_level` stays 64
  - the new row is read out last after draining, which checks wrap-around
- Assert `reset` while 10 rows are held and `rd`=1:
  - next cycle `o_level`=0, `o_out_vld`=0, `out`=0, flags cleared
- Random per-lane `wr` with random `rd` for 10k cycles:
  - the popped row stream matches a per-lane queue model exactly

Source files
------------

// File: rtl/ofifo_pkg.sv
// ofifo_pkg: shared widths, defaults and sizing helpers for the banked output FIFO.
package ofifo_pkg;

    // Default geometry of the column output buffer.
    localparam int COL_DEF   = 8;
    localparam int BW_DEF    = 4;
    localparam int DEPTH_DEF = 64;

    // Pointer width: wraps naturally because DEPTH is a power of two.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Count width: one extra bit so a full lane (count == DEPTH) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int PTR_W_DEF = $clog2(DEPTH_DEF);
    localparam int CNT_W_DEF = $clog2(DEPTH_DEF) + 1;

endpackage

// File: rtl/ofifo_lane.sv
// ofifo_lane: one BW-wide, DEPTH-deep FIFO lane with a combinational head.
// push/pop arrive already qualified by the bank: push never targets a full lane
// unless pop happens in the same cycle, and pop never targets an empty lane.
module ofifo_lane
    import ofifo_pkg::*;
#(
    parameter int BW    = BW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [BW-1:0]              din,
    output logic [BW-1:0]              dout,
    output logic [cnt_w(DEPTH)-1:0]    count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [BW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage array: written on push, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CNT_FULL);
    assign empty = (r_count == '0);

endmodule

// File: rtl/ofifo_banked.sv
// ofifo_banked: COL independent FIFO lanes written per column, drained a full row
// at a time once every lane holds data. Row output is registered with a valid pulse.
// Optional sticky overflow/underflow flags are built when OFIFO_ERR_EN is defined.
module ofifo_banked
    import ofifo_pkg::*;
#(
    parameter int COL    = COL_DEF,
    parameter int BW     = BW_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AF_LVL = DEPTH - 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [BW*COL-1:0]          in,
    input  logic [COL-1:0]             wr,
    input  logic                       rd,
    output logic [BW*COL-1:0]          out,
    output logic                       o_out_vld,
    output logic                       o_valid,
    output logic                       o_empty,
    output logic                       o_ready,
    output logic                       o_full,
    output logic                       o_afull,
    output logic [cnt_w(DEPTH)-1:0]    o_level
`ifdef OFIFO_ERR_EN
    ,
    output logic                       o_ovf,
    output logic                       o_udf
`endif
);

    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] AF_CNT = CW'(AF_LVL);

    logic [COL-1:0]         w_push;
    logic [COL-1:0]         w_full;
    logic [COL-1:0]         w_empty;
    logic [COL-1:0]         w_af;
    logic [CW-1:0]          w_count [COL];
    logic [CW-1:0]          w_min   [COL];
    logic [BW*COL-1:0]      w_head;
    logic                   w_valid;
    logic                   w_rd_acc;

    logic [BW*COL-1:0]      r_out;
    logic                   r_out_vld;

    // A row is only available when every lane has something to give.
    assign w_valid  = ~|w_empty;
    assign w_rd_acc = rd & w_valid;

    generate
        for (genvar gi = 0; gi < COL; gi++) begin : g_lane
            // A full lane can still take a write when the row pop frees a slot this cycle.
            assign w_push[gi] = wr[gi] & (~w_full[gi] | w_rd_acc);
            assign w_af[gi]   = (w_count[gi] >= AF_CNT);

            ofifo_lane #(
                .BW    (BW),
                .DEPTH (DEPTH)
            ) u_lane (
                .clk   (clk),
                .reset (reset),
                .push  (w_push[gi]),
                .pop   (w_rd_acc),
                .din   (in[BW*gi +: BW]),
                .dout  (w_head[BW*gi +: BW]),
                .count (w_count[gi]),
                .full  (w_full[gi]),
                .empty (w_empty[gi])
            );

            // Running minimum across lanes gives the number of complete rows.
            if (gi == 0) begin : g_min_first
                assign w_min[gi] = w_count[gi];
            end else begin : g_min_next
                assign w_min[gi] = (w_count[gi] < w_min[gi-1]) ? w_count[gi] : w_min[gi-1];
            end
        end
    endgenerate

    // Output row register: captures the heads on an accepted pop, holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out     <= '0;
            r_out_vld <= 1'b0;
        end else begin
            r_out_vld <= w_rd_acc;
            if (w_rd_acc) begin
                r_out <= w_head;
            end
        end
    end

`ifdef OFIFO_ERR_EN
    logic r_ovf;
    logic r_udf;

    // Sticky error flags: dropped lane writes and reads with no complete row.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | (|(wr & w_full & {COL{~w_rd_acc}}));
            r_udf <= r_udf | (rd & ~w_valid);
        end
    end

    assign o_ovf = r_ovf;
    assign o_udf = r_udf;
`endif

    assign out       = r_out;
    assign o_out_vld = r_out_vld;
    assign o_valid   = w_valid;
    assign o_empty   = &w_empty;
    assign o_ready   = ~|w_full;
    assign o_full    = &w_full;
    assign o_afull   = |w_af;
    assign o_level   = w_min[COL-1];

endmodule

// File: tb/tb_ofifo_banked.sv
// tb_ofifo_banked: directed and random checks of the banked output FIFO.
// Error-flag checks are compiled in when OFIFO_ERR_EN is defined.
module tb_ofifo_banked;

    localparam int COL   = 8;
    localparam int BW    = 4;
    localparam int DEPTH = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                clk = 1'b0;
    logic                reset;
    logic [BW*COL-1:0]   in_data;
    logic [COL-1:0]      wr;
    logic                rd;
    logic [BW*COL-1:0]   out_data;
    logic                o_out_vld;
    logic                o_valid;
    logic                o_empty;
    logic                o_ready;
    logic                o_full;
    logic                o_afull;
    logic [CW-1:0]       o_level;
`ifdef OFIFO_ERR_EN
    logic                o_ovf;
    logic                o_udf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ofifo_banked #(
        .COL    (COL),
        .BW     (BW),
        .DEPTH  (DEPTH),
        .AF_LVL (DEPTH - 4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in_data),
        .wr        (wr),
        .rd        (rd),
        .out       (out_data),
        .o_out_vld (o_out_vld),
        .o_valid   (o_valid),
        .o_empty   (o_empty),
        .o_ready   (o_ready),
        .o_full    (o_full),
        .o_afull   (o_afull),
        .o_level   (o_level)
`ifdef OFIFO_ERR_EN
        ,
        .o_ovf     (o_ovf),
        .o_udf     (o_udf)
`endif
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW*COL-1:0] rep(input logic [3:0] v);
        return {COL{v}};
    endfunction

    // Distinct row pattern per index (odd multiplier is a bijection mod 2^32).
    function automatic logic [BW*COL-1:0] rowval(input int k);
        return 32'(k) * 32'h9E37_79B1;
    endfunction

    task automatic do_reset();
        reset = 1'b1; wr = '0; rd = 1'b0; in_data = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        rd = 1'b0; wr = '0; in_data = '0; reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_tests++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", o_empty); end
        n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        n_tests++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", o_full); end
        n_tests++; if (o_afull !== 1'b0) begin n_fail++; $display("FAIL reset_afull got=%b exp=0", o_afull); end
        n_tests++; if (o_level !== '0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", o_level); end
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out got=%h exp=0", out_data); end
        n_tests++; if (o_out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld got=%b exp=0", o_out_vld); end
`ifdef OFIFO_ERR_EN
        n_tests++; if ({o_ovf, o_udf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b exp=00", {o_ovf, o_udf}); end
`endif
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic();
        for (int r = 1; r <= 4; r++) begin
            in_data = rep(4'(r)); wr = '1;
            tick();
        end
        wr = '0;
        n_tests++; if (o_level !== CW'(4)) begin n_fail++; $display("FAIL basic_level4 got=%0d exp=4", o_level); end
        n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", o_valid); end
        for (int r = 1; r <= 4; r++) begin
            rd = 1'b1;
            tick();
            $display("[TB] basic pop %0d out=%h vld=%b", r, out_data, o_out_vld);
            n_tests++; if (out_data !== rep(4'(r))) begin n_fail++; $display("FAIL basic_row%0d got=%h exp=%h", r, out_data, rep(4'(r))); end
            n_tests++; if (o_out_vld !== 1'b1) begin n_fail++; $display("FAIL basic_vld%0d got=%b exp=1", r, o_out_vld); end
        end
        rd = 1'b0;
        n_tests++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty got=%b exp=1", o_empty); end
        n_tests++; if (o_level !== '0) begin n_fail++; $display("FAIL basic_level0 got=%0d exp=0", o_level); end
        tick();
        n_tests++; if (o_out_vld !== 1'b0) begin n_fail++; $display("FAIL basic_vld_pulse got=%b exp=0", o_out_vld); end
        n_tests++; if (out_data !== rep(4'h4)) begin n_fail++; $display("FAIL basic_hold got=%h exp=%h", out_data, rep(4'h4)); end
    endtask

    task automatic test_partial();
        for (int k = 0; k < 3; k++) begin
            in_data = rep(4'h9); wr = 8'h01;
            tick();
        end
        wr = '0;
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL partial_valid got=%b exp=0", o_valid); end
        n_tests++; if (o_empty !== 1'b0) begin n_fail++; $display("FAIL partial_empty got=%b exp=0", o_empty); end
        n_tests++; if (o_level !== '0) begin n_fail++; $display("FAIL partial_level got=%0d exp=0", o_level); end
        rd = 1'b1;
        tick();
        rd = 1'b0;
        n_tests++; if (o_out_vld !== 1'b0) begin n_fail++; $display("FAIL partial_out_vld got=%b exp=0", o_out_vld); end
        n_tests++; if (out_data !== rep(4'h4)) begin n_fail++; $display("FAIL partial_hold got=%h exp=%h", out_data, rep(4'h4)); end
        n_tests++; if (o_level !== '0) begin n_fail++; $display("FAIL partial_level2 got=%0d exp=0", o_level); end
`ifdef OFIFO_ERR_EN
        n_tests++; if (o_udf !== 1'b1) begin n_fail++; $display("FAIL partial_udf got=%b exp=1", o_udf); end
        n_tests++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL partial_ovf got=%b exp=0", o_ovf); end
`endif
        do_reset();
    endtask

    task automatic test_no_bypass();
        in_data = rep(4'hB); wr = '1; rd = 1'b1;
        tick();
        wr = '0;
        n_tests++; if (o_out_vld !== 1'b0) begin n_fail++; $display("FAIL nobyp_vld got=%b exp=0", o_out_vld); end
        n_tests++; if (o_level !== CW'(1)) begin n_fail++; $display("FAIL nobyp_level got=%0d exp=1", o_level); end
        tick();
        rd = 1'b0;
        n_tests++; if (o_out_vld !== 1'b1) begin n_fail++; $display("FAIL nobyp_vld2 got=%b exp=1", o_out_vld); end
        n_tests++; if (out_data !== rep(4'hB)) begin n_fail++; $display("FAIL nobyp_out got=%h exp=%h", out_data, rep(4'hB)); end
        n_tests++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL nobyp_empty got=%b exp=1", o_empty); end
        do_reset();
    endtask

    task automatic test_fill_and_wrap();
        for (int k = 0; k < DEPTH; k++) begin
            in_data = rowval(k); wr = '1;
            tick();
            if (k + 1 == 59) begin
                n_tests++; if (o_afull !== 1'b0) begin n_fail++; $display("FAIL fill_afull59 got=%b exp=0", o_afull); end
            end
            if (k + 1 == 60) begin
                n_tests++; if (o_afull !== 1'b1) begin n_fail++; $display("FAIL fill_afull60 got=%b exp=1", o_afull); end
            end
            if (k + 1 == 63) begin
                n_tests++; if ({o_full, o_ready} !== 2'b01) begin n_fail++; $display("FAIL fill_63 full,ready got=%b exp=01", {o_full, o_ready}); end
            end
        end
        wr = '0;
        n_tests++; if ({o_full, o_ready} !== 2'b10) begin n_fail++; $display("FAIL fill_64 full,ready got=%b exp=10", {o_full, o_ready}); end
        n_tests++; if (o_level !== CW'(64)) begin n_fail++; $display("FAIL fill_level got=%0d exp=64", o_level); end
        in_data = rep(4'hF); wr = '1;
        tick();
        wr = '0;
        n_tests++; if (o_level !== CW'(64)) begin n_fail++; $display("FAIL drop_level got=%0d exp=64", o_level); end
        n_tests++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL drop_full got=%b exp=1", o_full); end
`ifdef OFIFO_ERR_EN
        n_tests++; if (o_ovf !== 1'b1) begin n_fail++; $display("FAIL drop_ovf got=%b exp=1", o_ovf); end
`endif
        in_data = rep(4'hA); wr = '1; rd = 1'b1;
        tick();
        wr = '0;
        n_tests++; if (out_data !== rowval(0)) begin n_fail++; $display("FAIL wrap_pop0 got=%h exp=%h", out_data, rowval(0)); end
        n_tests++; if (o_out_vld !== 1'b1) begin n_fail++; $display("FAIL wrap_vld got=%b exp=1", o_out_vld); end
        n_tests++; if (o_level !== CW'(64)) begin n_fail++; $display("FAIL wrap_level got=%0d exp=64", o_level); end
        for (int j = 1; j <= DEPTH; j++) begin
            logic [BW*COL-1:0] exp_row;
            exp_row = (j == DEPTH) ? rep(4'hA) : rowval(j);
            tick();
            n_tests++; if (out_data !== exp_row || o_out_vld !== 1'b1) begin
                n_fail++; $display("FAIL wrap_drain%0d got=%h/%b exp=%h/1", j, out_data, o_out_vld, exp_row);
            end
        end
        rd = 1'b0;
        n_tests++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got=%b exp=1", o_empty); end
        $display("[TB] test_fill_and_wrap done");
    endtask

    task automatic test_reset_mid();
        rd = 1'b1;
        tick();
        rd = 1'b0;
`ifdef OFIFO_ERR_EN
        n_tests++; if (o_udf !== 1'b1) begin n_fail++; $display("FAIL mid_udf_pre got=%b exp=1", o_udf); end
`endif
        for (int k = 0; k < 10; k++) begin
            in_data = rowval(100 + k); wr = '1;
            tick();
        end
        wr = '0;
        n_tests++; if (o_level !== CW'(10)) begin n_fail++; $display("FAIL mid_level10 got=%0d exp=10", o_level); end
        rd = 1'b1; reset = 1'b1;
        tick();
        rd = 1'b0; reset = 1'b0;
        n_tests++; if (o_level !== '0) begin n_fail++; $display("FAIL mid_level got=%0d exp=0", o_level); end
        n_tests++; if (o_out_vld !== 1'b0) begin n_fail++; $display("FAIL mid_vld got=%b exp=0", o_out_vld); end
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL mid_out got=%h exp=0", out_data); end
        n_tests++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty got=%b exp=1", o_empty); end
`ifdef OFIFO_ERR_EN
        n_tests++; if ({o_ovf, o_udf} !== 2'b00) begin n_fail++; $display("FAIL mid_flags got=%b exp=00", {o_ovf, o_udf}); end
`endif
    endtask

    task automatic test_random();
        logic [BW-1:0]     q [COL][$];
        logic [BW*COL-1:0] exp_row;
        logic [COL-1:0]    wr_v;
        logic              rd_v;
        logic              acc;
        bit                all_ne;
        int                minv;
        int                pct;
        int                pops;
        pops = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            pct = (cyc < 5000) ? 30 : 70;
            wr_v = COL'($urandom);
            rd_v = ($urandom_range(0, 99) < pct);
            in_data = $urandom;
            wr = wr_v; rd = rd_v;
            all_ne = 1'b1;
            for (int i = 0; i < COL; i++) if (q[i].size() == 0) all_ne = 1'b0;
            acc = rd_v & all_ne;
            exp_row = '0;
            if (acc) for (int i = 0; i < COL; i++) exp_row[BW*i +: BW] = q[i][0];
            tick();
            for (int i = 0; i < COL; i++) begin
                bit was_full;
                was_full = (q[i].size() == DEPTH);
                if (acc) void'(q[i].pop_front());
                if (wr_v[i] && (!was_full || acc)) q[i].push_back(in_data[BW*i +: BW]);
            end
            minv = DEPTH;
            for (int i = 0; i < COL; i++) if (q[i].size() < minv) minv = q[i].size();
            n_tests++; if (o_out_vld !== acc) begin n_fail++; $display("FAIL rand_vld cyc=%0d got=%b exp=%b", cyc, o_out_vld, acc); end
            if (acc) begin
                pops++;
                n_tests++; if (out_data !== exp_row) begin n_fail++; $display("FAIL rand_row cyc=%0d got=%h exp=%h", cyc, out_data, exp_row); end
            end
            n_tests++; if (o_level !== CW'(minv)) begin n_fail++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", cyc, o_level, minv); end
        end
        wr = '0; rd = 1'b0;
        $display("[TB] test_random done, %0d rows popped", pops);
    endtask

    initial begin
        reset = 1'b1; wr = '0; rd = 1'b0; in_data = '0;
        test_reset();
        test_basic();
        test_partial();
        test_no_bypass();
        test_fill_and_wrap();
        test_reset_mid();
        do_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
